// File: rtl/h14tx_decoding_top.sv
// h14tx_decoding_top: three-channel HDMI 1.4 receive-side symbol decoder.
// Classifies each symbol triple into a period type and recovers control bits,
// TERC4 nibbles and TMDS video bytes. Two pipeline stages: stage 1 registers
// the symbols with per-channel code flags, stage 2 runs the period FSM and
// registers all outputs, so a symbol presented at cycle N is reported at N+2.
// Optional feature macro: H14TX_DECODING_ERR_CNT_EN adds a saturating err_cnt.
// period encoding: 0 Control, 1 VideoPreamble, 2 DataIslandPreamble,
// 3 VideoGuard, 4 DataIslandGuard, 5 VideoActive, 6 DataIslandActive.
module h14tx_decoding_top #(
  parameter int PreambleLen = 8,
  parameter int MaxPackets  = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0][9:0]  symbol,
  output logic [2:0]       period,
  output logic [2:0][1:0]  ctl,
  output logic [2:0][3:0]  data,
  output logic [2:0][7:0]  video,
  output logic             err
`ifdef H14TX_DECODING_ERR_CNT_EN
  ,
  output logic [15:0]      err_cnt
`endif
);

  localparam logic [2:0] P_CONTROL = 3'd0;
  localparam logic [2:0] P_VID_PRE = 3'd1;
  localparam logic [2:0] P_DI_PRE  = 3'd2;
  localparam logic [2:0] P_VID_GRD = 3'd3;
  localparam logic [2:0] P_DI_GRD  = 3'd4;
  localparam logic [2:0] P_VID_ACT = 3'd5;
  localparam logic [2:0] P_DI_ACT  = 3'd6;

  localparam logic [9:0] VID_GUARD_02 = 10'b1011001100;
  localparam logic [9:0] GUARD_1      = 10'b0100110011;

  localparam logic [4:0] PRE_LEN = 5'(PreambleLen);
  localparam logic [7:0] MAX_PKT = 8'(MaxPackets);

  typedef enum logic [2:0] {
    S_CONTROL,
    S_VID_GUARD,
    S_VID_ACTIVE,
    S_DI_GUARD_LEAD,
    S_DI_ACTIVE,
    S_DI_GUARD_TRAIL
  } state_t;

  // TMDS video decode: undo the optional inversion, then undo the XOR/XNOR chain
  function automatic logic [7:0] tmds_decode(input logic [9:0] q);
    logic [7:0] b;
    logic [7:0] d;
    b = q[9] ? ~q[7:0] : q[7:0];
    d[0] = b[0];
    for (int k = 1; k < 8; k++) begin
      d[k] = q[8] ? (b[k] ^ b[k-1]) : ~(b[k] ^ b[k-1]);
    end
    return d;
  endfunction

  logic [2:0]      is_ctl_d, is_terc_d;
  logic [2:0][1:0] ctl_val_d;
  logic [2:0][3:0] terc_val_d;
  logic            vid_guard_d, di_guard_d;

  logic            v1;
  logic [2:0][9:0] sym1;
  logic [2:0]      is_ctl1, is_terc1;
  logic [2:0][1:0] ctl_val1;
  logic [2:0][3:0] terc_val1;
  logic            vid_guard1, di_guard1;

  state_t          state, state_nx;
  logic [4:0]      run, run_nx, run_incl;
  logic            last_pre, last_pre_nx;
  logic [4:0]      sym_cnt, sym_cnt_nx;
  logic [7:0]      pkt_cnt, pkt_cnt_nx;

  logic [2:0]      period_nx;
  logic [2:0][1:0] ctl_nx;
  logic [2:0][3:0] data_nx;
  logic [2:0][7:0] video_nx;
  logic            err_nx;

  logic            all_ctl, all_terc, vid_pre, di_pre, is_pre, di_guard_full;
  logic            show_ctl, show_data0, show_data_all, show_video;

  // Per-channel code classification of the incoming symbols
  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      is_ctl_d[ch]   = 1'b1;
      ctl_val_d[ch]  = 2'b00;
      is_terc_d[ch]  = 1'b1;
      terc_val_d[ch] = 4'h0;
      case (symbol[ch])
        10'b1101010100: ctl_val_d[ch] = 2'b00;
        10'b0010101011: ctl_val_d[ch] = 2'b01;
        10'b0101010100: ctl_val_d[ch] = 2'b10;
        10'b1010101011: ctl_val_d[ch] = 2'b11;
        default:        is_ctl_d[ch]  = 1'b0;
      endcase
      case (symbol[ch])
        10'b1010011100: terc_val_d[ch] = 4'h0;
        10'b1001100011: terc_val_d[ch] = 4'h1;
        10'b1011100100: terc_val_d[ch] = 4'h2;
        10'b1011100010: terc_val_d[ch] = 4'h3;
        10'b0101110001: terc_val_d[ch] = 4'h4;
        10'b0100011110: terc_val_d[ch] = 4'h5;
        10'b0110001110: terc_val_d[ch] = 4'h6;
        10'b0100111100: terc_val_d[ch] = 4'h7;
        10'b1011001100: terc_val_d[ch] = 4'h8;
        10'b0100111001: terc_val_d[ch] = 4'h9;
        10'b0110011100: terc_val_d[ch] = 4'hA;
        10'b1011000110: terc_val_d[ch] = 4'hB;
        10'b1010001110: terc_val_d[ch] = 4'hC;
        10'b1001110001: terc_val_d[ch] = 4'hD;
        10'b0101100011: terc_val_d[ch] = 4'hE;
        10'b1011000011: terc_val_d[ch] = 4'hF;
        default:        is_terc_d[ch]  = 1'b0;
      endcase
    end
    vid_guard_d = (symbol[0] == VID_GUARD_02) && (symbol[1] == GUARD_1) &&
                  (symbol[2] == VID_GUARD_02);
    di_guard_d  = (symbol[1] == GUARD_1) && (symbol[2] == GUARD_1);
  end

  // Stage 1: register symbols and their classification; v1 marks real data after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      v1         <= 1'b0;
      sym1       <= '0;
      is_ctl1    <= '0;
      ctl_val1   <= '0;
      is_terc1   <= '0;
      terc_val1  <= '0;
      vid_guard1 <= 1'b0;
      di_guard1  <= 1'b0;
    end else begin
      v1         <= 1'b1;
      sym1       <= symbol;
      is_ctl1    <= is_ctl_d;
      ctl_val1   <= ctl_val_d;
      is_terc1   <= is_terc_d;
      terc_val1  <= terc_val_d;
      vid_guard1 <= vid_guard_d;
      di_guard1  <= di_guard_d;
    end
  end

  // Stage 2: preamble run tracking, period FSM next state and gated outputs
  always_comb begin
    all_ctl       = &is_ctl1;
    all_terc      = &is_terc1;
    vid_pre       = all_ctl && (ctl_val1[1] == 2'b01) && (ctl_val1[2] == 2'b00);
    di_pre        = all_ctl && (ctl_val1[1] == 2'b01) && (ctl_val1[2] == 2'b01);
    is_pre        = vid_pre || di_pre;
    di_guard_full = di_guard1 && is_terc1[0] && (terc_val1[0][3:2] == 2'b11);

    run_incl = 5'd0;
    if (is_pre) begin
      if ((run != 5'd0) && (last_pre == di_pre)) begin
        run_incl = (run == 5'd31) ? run : run + 5'd1;
      end else begin
        run_incl = 5'd1;
      end
    end

    state_nx      = state;
    run_nx        = run;
    last_pre_nx   = last_pre;
    sym_cnt_nx    = sym_cnt;
    pkt_cnt_nx    = pkt_cnt;
    period_nx     = P_CONTROL;
    err_nx        = 1'b0;
    show_ctl      = 1'b0;
    show_data0    = 1'b0;
    show_data_all = 1'b0;
    show_video    = 1'b0;

    if (v1) begin
      run_nx      = run_incl;
      last_pre_nx = is_pre ? di_pre : last_pre;
      case (state)
        S_CONTROL: begin
          if (vid_guard1 && (run >= PRE_LEN)) begin
            state_nx  = S_VID_GUARD;
            period_nx = P_VID_GRD;
          end else if (di_guard_full && (run >= PRE_LEN)) begin
            state_nx   = S_DI_GUARD_LEAD;
            period_nx  = P_DI_GRD;
            show_data0 = 1'b1;
          end else if (!all_ctl) begin
            err_nx = 1'b1;
          end else begin
            show_ctl = 1'b1;
            if (run_incl >= PRE_LEN) begin
              period_nx = vid_pre ? P_VID_PRE : P_DI_PRE;
            end
          end
        end
        S_VID_GUARD: begin
          if (vid_guard1) begin
            state_nx  = S_VID_ACTIVE;
            period_nx = P_VID_GRD;
          end else begin
            err_nx = 1'b1;
          end
        end
        S_VID_ACTIVE: begin
          if (is_ctl1[0]) begin
            state_nx = S_CONTROL;
            show_ctl = 1'b1;
          end else begin
            period_nx  = P_VID_ACT;
            show_video = 1'b1;
          end
        end
        S_DI_GUARD_LEAD: begin
          if (di_guard_full) begin
            state_nx   = S_DI_ACTIVE;
            period_nx  = P_DI_GRD;
            show_data0 = 1'b1;
            sym_cnt_nx = 5'd0;
            pkt_cnt_nx = 8'd0;
          end else begin
            err_nx = 1'b1;
          end
        end
        S_DI_ACTIVE: begin
          if ((sym_cnt == 5'd0) && (pkt_cnt != 8'd0) && di_guard_full) begin
            state_nx   = S_DI_GUARD_TRAIL;
            period_nx  = P_DI_GRD;
            show_data0 = 1'b1;
          end else if (!all_terc) begin
            err_nx = 1'b1;
          end else if ((sym_cnt == 5'd0) && (pkt_cnt >= MAX_PKT)) begin
            err_nx = 1'b1;
          end else begin
            period_nx     = P_DI_ACT;
            show_data_all = 1'b1;
            sym_cnt_nx    = sym_cnt + 5'd1;
            if (sym_cnt == 5'd0) begin
              pkt_cnt_nx = pkt_cnt + 8'd1;
            end
          end
        end
        S_DI_GUARD_TRAIL: begin
          if (di_guard_full) begin
            state_nx   = S_CONTROL;
            period_nx  = P_DI_GRD;
            show_data0 = 1'b1;
          end else begin
            err_nx = 1'b1;
          end
        end
        default: state_nx = S_CONTROL;
      endcase

      if (err_nx) begin
        state_nx      = S_CONTROL;
        period_nx     = P_CONTROL;
        sym_cnt_nx    = 5'd0;
        pkt_cnt_nx    = 8'd0;
        show_ctl      = 1'b0;
        show_data0    = 1'b0;
        show_data_all = 1'b0;
        show_video    = 1'b0;
      end
    end

    for (int ch = 0; ch < 3; ch++) begin
      ctl_nx[ch]   = show_ctl ? ctl_val1[ch] : 2'b00;
      video_nx[ch] = show_video ? tmds_decode(sym1[ch]) : 8'h00;
      data_nx[ch]  = show_data_all ? terc_val1[ch] : 4'h0;
    end
    if (show_data0) begin
      data_nx[0] = terc_val1[0];
    end
  end

  // Stage 2 registers: FSM state, counters and the registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_CONTROL;
      run      <= 5'd0;
      last_pre <= 1'b0;
      sym_cnt  <= 5'd0;
      pkt_cnt  <= 8'd0;
      period   <= P_CONTROL;
      ctl      <= '0;
      data     <= '0;
      video    <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nx;
      run      <= run_nx;
      last_pre <= last_pre_nx;
      sym_cnt  <= sym_cnt_nx;
      pkt_cnt  <= pkt_cnt_nx;
      period   <= period_nx;
      ctl      <= ctl_nx;
      data     <= data_nx;
      video    <= video_nx;
      err      <= err_nx;
    end
  end

`ifdef H14TX_DECODING_ERR_CNT_EN
  // Saturating count of error pulses, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= 16'h0000;
    end else if (err_nx && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'h0001;
    end
  end
`endif

endmodule
